piso_bit_serializer: RTL

- Upstream stimulus stage for the serial sequence detectors, such as the Mealy "1011" detector.
- Accepts parallel words through a valid/ready handshake and buffers them in a small synchronous FIFO.
- Shifts each word out one bit per consumed cycle onto a single-bit serial line with a valid/ready qualifier.
- ser_out drives the detector din input directly; the detector has no backpressure, so its instance ties ser_ready=1.

---
 rtl/piso_pkg.sv | 25 ++
 rtl/piso_fifo.sv | 79 +++++++
 rtl/piso_bit_serializer.sv | 115 +++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in / serial-out bit serializer.
//   state_e : shifter FSM encoding
//   clog2   : ceiling log2, usable in constant expressions
//   CNT_W   : bit-counter width for the default 8-bit word
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Smallest r such that 2**r >= v (0 for v <= 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned CNT_W     = $clog2(DEF_WIDTH);

endpackage

// File: rtl/piso_fifo.sv
// Synchronous show-ahead FIFO buffering parallel words ahead of the shifter.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   wr_en       : write wr_data this edge (ignored while full)
//   wr_data     : word to store
//   rd_en       : pop the head word this edge (ignored while empty)
//   rd_data     : head word, valid whenever empty is low
//   count       : occupancy, one bit wider than the pointers
//   full, empty : occupancy flags decoded from the registered count
module piso_fifo
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        rd_data,
  output logic [clog2(DEPTH):0]   count,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned FCW   = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FCW-1:0]   count_q, count_d;
  logic             do_wr, do_rd;

  assign full    = (count_q == FCW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  // Pointer/count update; pointers wrap naturally at DEPTH.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + FCW'(1);
      2'b01:   count_d = count_q - FCW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/piso_bit_serializer.sv
// Parallel-in / serial-out serializer: words enter through a FIFO and are
// shifted out one bit per consumed cycle on a valid/ready serial line.
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   in_data/in_valid     : parallel word input, accepted when in_ready is high
//   in_ready             : FIFO not full
//   ser_out/ser_valid    : registered serial bit and its qualifier
//   ser_ready            : consumer takes ser_out at this edge
//   busy                 : shifter holds a word or FIFO is not empty
//   fifo_count           : FIFO occupancy
module piso_bit_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  ser_out,
  output logic                  ser_valid,
  input  logic                  ser_ready,
  output logic                  busy,
  output logic [clog2(DEPTH):0] fifo_count
);

  localparam int unsigned BCW = clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             pop, push, consume;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             fifo_full, fifo_empty;

  assign in_ready  = ~fifo_full;
  assign push      = in_valid & ~fifo_full;
  assign consume   = ser_valid_q & ser_ready;
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign busy      = (state_q == SHIFT) | ~fifo_empty;

  piso_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Shifter FSM: the current bit always sits at the outgoing end of sh_q.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcnt_d  = bcnt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_d    = fifo_rd_data;
          bcnt_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (consume) begin
          if (bcnt_q != BCW'(WIDTH - 1)) begin
            sh_d   = (MSB_FIRST != 0) ? (sh_q << 1) : (sh_q >> 1);
            bcnt_d = bcnt_q + BCW'(1);
          end else if (!fifo_empty) begin
            // Reload on the last bit so consecutive words have no gap.
            pop    = 1'b1;
            sh_d   = fifo_rd_data;
            bcnt_d = '0;
          end else begin
            bcnt_d  = '0;
            state_d = IDLE;
          end
        end
      end
    endcase
    ser_valid_d = (state_d == SHIFT);
    ser_out_d   = ser_valid_d & ((MSB_FIRST != 0) ? sh_d[WIDTH-1] : sh_d[0]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      bcnt_q      <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      bcnt_q      <= bcnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
    end
  end

endmodule
